// File: rtl/loxodes_sequencer_pg.sv
// Power-rail sequencer: ramps N_CH channel enables up/down as a thermometer code,
// gating each up-step on the previous channel's power-good and trapping to FAULT on loss.
module loxodes_sequencer_pg #(
  parameter int N_CH     = 8,
  parameter int DELAY_W  = 5,
  parameter int PG_TMO   = 16,
  parameter int PG_CHECK = 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         enable,
  input  logic [DELAY_W-1:0]           delay_up,
  input  logic [DELAY_W-1:0]           delay_down,
  input  logic [N_CH-1:0]              pgood,
  input  logic                         fault_clr,
  output logic [N_CH-1:0]              ch_en,
  output logic [$clog2(N_CH+1)-1:0]    ch_count,
  output logic [2:0]                   state,
  output logic                         all_on,
  output logic                         all_off,
  output logic                         fault,
  output logic [$clog2(N_CH)-1:0]      fault_ch
);

  localparam int IDX_W = $clog2(N_CH + 1);
  localparam int FCH_W = $clog2(N_CH);
  localparam int CNT_W = DELAY_W + $clog2(PG_TMO) + 1;

  typedef enum logic [2:0] {
    S_OFF       = 3'd0,
    S_RAMP_UP   = 3'd1,
    S_ON        = 3'd2,
    S_RAMP_DOWN = 3'd3,
    S_FAULT     = 3'd4
  } state_t;

  state_t             st, st_nx;
  logic [IDX_W-1:0]   idx, idx_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx, cnt_inc, limit;
  logic [FCH_W-1:0]   fch, fch_nx, on_ch;
  logic [N_CH-1:0]    pg_eff;
  logic               pg_prev, on_bad, tmo_hit, up_due, down_due;

  function automatic logic [N_CH-1:0] therm(input logic [IDX_W-1:0] n);
    logic [N_CH-1:0] t;
    for (int i = 0; i < N_CH; i++) t[i] = (IDX_W'(i) < n);
    return t;
  endfunction

  assign pg_eff   = (PG_CHECK != 0) ? pgood : '1;
  assign limit    = CNT_W'(delay_up) + CNT_W'(PG_TMO);
  assign cnt_inc  = (cnt < limit) ? cnt + CNT_W'(1) : cnt;
  // Timeout fires on the edge where the counter reaches its saturation value.
  assign tmo_hit  = (cnt_inc >= limit);
  assign up_due   = (cnt >= CNT_W'(delay_up));
  assign down_due = (cnt >= CNT_W'(delay_down));

  // State and sequencing registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      st    <= S_OFF;
      idx   <= '0;
      cnt   <= '0;
      fch   <= '0;
      ch_en <= '0;
    end else begin
      st    <= st_nx;
      idx   <= idx_nx;
      cnt   <= cnt_nx;
      fch   <= fch_nx;
      ch_en <= therm(idx_nx);
    end
  end

  // Next-state, step and fault decisions
  always_comb begin
    pg_prev = 1'b1;
    for (int i = 0; i < N_CH; i++)
      if (idx == IDX_W'(i + 1)) pg_prev = pg_eff[i];

    on_bad = 1'b0;
    on_ch  = '0;
    for (int i = N_CH - 1; i >= 0; i--)
      if (ch_en[i] && !pg_eff[i]) begin
        on_bad = 1'b1;
        on_ch  = FCH_W'(i);
      end

    st_nx  = st;
    idx_nx = idx;
    cnt_nx = cnt_inc;
    fch_nx = fch;

    case (st)
      S_OFF: begin
        if (enable) begin
          st_nx  = S_RAMP_UP;
          cnt_nx = '0;
        end
      end
      S_RAMP_UP: begin
        if (idx != '0 && !pg_prev && tmo_hit) begin
          st_nx  = S_FAULT;
          idx_nx = '0;
          cnt_nx = '0;
          fch_nx = FCH_W'(idx - IDX_W'(1));
        end else if (!enable) begin
          st_nx  = S_RAMP_DOWN;
          cnt_nx = '0;
        end else if (idx == IDX_W'(N_CH)) begin
          if (pg_prev) begin
            st_nx  = S_ON;
            cnt_nx = '0;
          end
        end else if (up_due && pg_prev) begin
          idx_nx = idx + IDX_W'(1);
          cnt_nx = '0;
        end
      end
      S_ON: begin
        if (on_bad) begin
          st_nx  = S_FAULT;
          idx_nx = '0;
          cnt_nx = '0;
          fch_nx = on_ch;
        end else if (!enable) begin
          st_nx  = S_RAMP_DOWN;
          cnt_nx = '0;
        end
      end
      S_RAMP_DOWN: begin
        if (enable) begin
          st_nx  = S_RAMP_UP;
          cnt_nx = '0;
        end else if (down_due) begin
          cnt_nx = '0;
          if (idx <= IDX_W'(1)) begin
            idx_nx = '0;
            st_nx  = S_OFF;
          end else begin
            idx_nx = idx - IDX_W'(1);
          end
        end
      end
      S_FAULT: begin
        if (fault_clr && !enable) begin
          st_nx  = S_OFF;
          cnt_nx = '0;
        end
      end
      default: begin
        st_nx  = S_OFF;
        idx_nx = '0;
        cnt_nx = '0;
      end
    endcase
  end

  // Status outputs
  always_comb begin
    state    = st;
    all_on   = (st == S_ON);
    all_off  = (st == S_OFF);
    fault    = (st == S_FAULT);
    ch_count = idx;
    fault_ch = fch;
  end

endmodule

// File: tb/tb_loxodes_sequencer_pg.sv
// Directed and randomized bench for loxodes_sequencer_pg (N_CH=4) against an
// edge-counting behavioural model of the sequencing rules.
module tb_loxodes_sequencer_pg;
  localparam int N   = 4;
  localparam int TMO = 16;

  logic       clk = 1'b0;
  logic       reset_n, enable, fault_clr;
  logic [4:0] delay_up, delay_down;
  logic [3:0] pgood, pg_kill;
  logic [3:0] ch_en;
  logic [2:0] ch_count, state;
  logic       all_on, all_off, fault;
  logic [1:0] fault_ch;

  int n_vec = 0;
  int n_err = 0;

  // Model: state code, channels on, edges since last step/state change, fault channel
  int m_state, m_idx, m_wait, m_fch;
  logic [3:0] m_en;

  loxodes_sequencer_pg #(.N_CH(N), .DELAY_W(5), .PG_TMO(TMO), .PG_CHECK(1)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .delay_up(delay_up),
    .delay_down(delay_down), .pgood(pgood), .fault_clr(fault_clr), .ch_en(ch_en),
    .ch_count(ch_count), .state(state), .all_on(all_on), .all_off(all_off),
    .fault(fault), .fault_ch(fault_ch)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    logic [3:0] pg;
    int w, du, dd, bad;
    pg = pgood;
    w  = m_wait + 1;
    du = int'(delay_up);
    dd = int'(delay_down);
    if (!reset_n) begin
      m_state = 0; m_idx = 0; m_wait = 0; m_fch = 0;
    end else begin
      m_wait = w;
      case (m_state)
        0: if (enable) begin m_state = 1; m_wait = 0; end
        1: begin
          bad = (m_idx > 0) && !pg[m_idx-1];
          if (bad != 0 && w >= du + TMO) begin
            m_fch = m_idx - 1; m_idx = 0; m_state = 4; m_wait = 0;
          end else if (!enable) begin
            m_state = 3; m_wait = 0;
          end else if (m_idx == N) begin
            if (bad == 0) begin m_state = 2; m_wait = 0; end
          end else if (bad == 0 && w > du) begin
            m_idx++; m_wait = 0;
          end
        end
        2: begin
          bad = -1;
          for (int i = m_idx - 1; i >= 0; i--) if (!pg[i]) bad = i;
          if (bad >= 0) begin
            m_fch = bad; m_idx = 0; m_state = 4; m_wait = 0;
          end else if (!enable) begin
            m_state = 3; m_wait = 0;
          end
        end
        3: begin
          if (enable) begin
            m_state = 1; m_wait = 0;
          end else if (w > dd) begin
            m_idx = (m_idx > 0) ? m_idx - 1 : 0;
            m_wait = 0;
            if (m_idx == 0) m_state = 0;
          end
        end
        default: if (fault_clr && !enable) begin m_state = 0; m_wait = 0; end
      endcase
    end
    m_en = 4'((1 << m_idx) - 1);
  endtask

  // One clock: drive pgood from the model's enables, advance model, check after the edge
  task automatic tick();
    pgood = m_en & ~pg_kill;
    model_step();
    @(posedge clk);
    #1;
    chk("ch_en", 32'(ch_en), 32'(m_en));
    chk("state", 32'(state), 32'(m_state));
    chk("ch_count", 32'(ch_count), 32'(m_idx));
    chk("all_on", 32'(all_on), 32'(m_state == 2));
    chk("all_off", 32'(all_off), 32'(m_state == 0));
    chk("fault", 32'(fault), 32'(m_state == 4));
    chk("fault_ch", 32'(fault_ch), 32'(m_fch));
  endtask

  initial begin
    m_state = 0; m_idx = 0; m_wait = 0; m_fch = 0; m_en = '0;
    reset_n = 1'b0; enable = 1'b1; fault_clr = 1'b0;
    delay_up = 5'd3; delay_down = 5'd1; pg_kill = '0; pgood = '0;
    @(negedge clk);

    // Reset held two cycles with enable asserted
    tick(); tick();
    chk("rst_ch_en", 32'(ch_en), 32'h0);
    chk("rst_state", 32'(state), 32'h0);
    chk("rst_all_off", 32'(all_off), 32'h1);

    // Ramp up with delay_up=3
    reset_n = 1'b1;
    tick();                        // E0
    repeat (4) tick();             // E4
    chk("e4_ch_en", 32'(ch_en), 32'h1);
    repeat (4) tick();             // E8
    chk("e8_ch_en", 32'(ch_en), 32'h3);
    repeat (8) tick();             // E16
    chk("e16_ch_en", 32'(ch_en), 32'hf);
    chk("e16_state", 32'(state), 32'h1);
    tick();                        // E17
    chk("e17_on", 32'(state), 32'h2);
    repeat (3) tick();

    // Ramp down with delay_down=1
    enable = 1'b0; delay_down = 5'd1;
    tick();                        // E0
    repeat (2) tick();             // E2
    chk("dn_e2", 32'(ch_en), 32'h7);
    repeat (2) tick();
    chk("dn_e4", 32'(ch_en), 32'h3);
    repeat (2) tick();
    chk("dn_e6", 32'(ch_en), 32'h1);
    repeat (2) tick();
    chk("dn_e8_en", 32'(ch_en), 32'h0);
    chk("dn_e8_off", 32'(state), 32'h0);

    // pgood[1] stuck low: timeout fault on channel 1
    pg_kill = 4'b0010; enable = 1'b1; delay_up = 5'd3;
    tick();                        // E0
    repeat (8) tick();             // E8
    chk("tmo_e8_en", 32'(ch_en), 32'h3);
    repeat (18) tick();            // E26
    chk("tmo_e26_state", 32'(state), 32'h1);
    tick();                        // E27
    chk("tmo_e27_state", 32'(state), 32'h4);
    chk("tmo_e27_en", 32'(ch_en), 32'h0);
    chk("tmo_e27_fch", 32'(fault_ch), 32'h1);

    // Fault clear requires enable low
    fault_clr = 1'b1;
    tick();
    chk("clr_en_hi", 32'(state), 32'h4);
    enable = 1'b0;
    tick();
    chk("clr_en_lo", 32'(state), 32'h0);
    fault_clr = 1'b0; pg_kill = '0;

    // Abort a ramp at two channels, then resume from one
    delay_up = 5'd1; delay_down = 5'd1; enable = 1'b1;
    tick();                        // E0 -> ramp up
    repeat (4) tick();             // E4: two channels on
    chk("ab_count2", 32'(ch_count), 32'h2);
    enable = 1'b0;
    tick();
    chk("ab_down", 32'(state), 32'h3);
    chk("ab_en_kept", 32'(ch_en), 32'h3);
    repeat (2) tick();
    chk("ab_count1", 32'(ch_count), 32'h1);
    enable = 1'b1;
    tick();
    chk("ab_resume", 32'(state), 32'h1);
    repeat (2) tick();
    chk("ab_ch1_back", 32'(ch_en), 32'h3);
    enable = 1'b0;
    for (int k = 0; k < 40 && m_state != 0; k++) tick();
    chk("ab_settled_off", 32'(state), 32'h0);

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      if (m_state == 0 && $urandom_range(0, 3) == 0) begin
        delay_up   = 5'($urandom_range(0, 7));
        delay_down = 5'($urandom_range(0, 7));
      end
      if ($urandom_range(0, 39) == 0) enable = ~enable;
      fault_clr = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 59) == 0)
        pg_kill = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      reset_n = ($urandom_range(0, 249) != 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/loxodes_sequencer_pg.md
LOXODES_SEQUENCER_PG -- requirements
Module: loxodes_sequencer_pg

Interface
- REQ-001: Parameter N_CH, default 8, number of sequenced channels (legal 2..16).
- REQ-002: Parameter DELAY_W, default 5, width of the delay inputs.
- REQ-003: Parameter PG_TMO, default 16, power-good timeout in cycles beyond delay_up.
- REQ-004: Parameter PG_CHECK, default 1; 0 treats pgood as all-ones internally.
- REQ-005: clk  input  1  sole clock, all logic on rising edge.
- REQ-006: reset_n  input  1  synchronous, active-low reset.
- REQ-007: enable  input  1  1 = sequence up, 0 = sequence down.
- REQ-008: delay_up  input  DELAY_W  cycles between up steps, sampled live.
- REQ-009: delay_down  input  DELAY_W  cycles between down steps, sampled live.
- REQ-010: pgood  input  N_CH  per-channel power-good feedback.
- REQ-011: fault_clr  input  1  fault acknowledge.
- REQ-012: ch_en  output  N_CH  registered channel enables.
- REQ-013: ch_count  output  clog2(N_CH+1)  number of enabled channels (idx).
- REQ-014: state  output  3  OFF=0, RAMP_UP=1, ON=2, RAMP_DOWN=3, FAULT=4.
- REQ-015: all_on / all_off / fault  output  1 each  high exactly when state is ON / OFF / FAULT.
- REQ-016: fault_ch  output  clog2(N_CH)  index of channel that caused the last fault.

Function
- REQ-017: Enables SHALL always be a thermometer code: ch_en[i]=1 iff i < idx.
- REQ-018: A step counter SHALL be cleared on every state change and every step, otherwise increment, saturating at delay_up+PG_TMO (width DELAY_W+clog2(PG_TMO)+1).
- REQ-019: OFF: enable=1 SHALL move to RAMP_UP with counter 0; otherwise hold.
- REQ-020: RAMP_UP: when counter>=delay_up, idx<N_CH and (idx==0 or pgood[idx-1]), SHALL set ch_en[idx], idx+1, counter 0.
- REQ-021: RAMP_UP: when idx==N_CH and pgood[N_CH-1]=1, SHALL move to ON (no additional delay).
- REQ-022: RAMP_UP: when idx>0, pgood[idx-1]=0 and counter==delay_up+PG_TMO, SHALL move to FAULT with fault_ch=idx-1.
- REQ-023: ON: any pgood[i]=0 with ch_en[i]=1 SHALL move to FAULT with fault_ch = lowest such i.
- REQ-024: RAMP_UP or ON with enable=0 SHALL move to RAMP_DOWN, counter 0, enables unchanged; a fault check on the same edge takes priority.
- REQ-025: RAMP_DOWN: when counter>=delay_down, SHALL clear ch_en[idx-1], idx-1, counter 0; on the edge idx reaches 0, SHALL move to OFF.
- REQ-026: RAMP_DOWN: pgood is ignored; enable=1 SHALL return to RAMP_UP from current idx with counter 0.
- REQ-027: FAULT entry SHALL clear all ch_en and idx on the same edge; fault_ch holds until next fault or reset.
- REQ-028: FAULT SHALL exit to OFF only when fault_clr=1 and enable=0 on the same edge; otherwise hold.
- REQ-029: delay value 0 SHALL give one step per cycle.

Reset
- REQ-030: reset_n=0 at a clock edge SHALL force state OFF, ch_en=0, idx=0, counter=0, fault_ch=0, from any state, mid-sequence included.
- REQ-031: Reset SHALL dominate all other inputs.

Verification (N_CH=4, PG_TMO=16, pgood=ch_en delayed one cycle unless stated)
- REQ-032: reset_n=0 two cycles with enable=1 -> ch_en=0000, state=0, all_off=1.
- REQ-033: enable=1 at E0, delay_up=3 -> ch_en[0] at E4; pgood[0] high E5 -> ch_en[1] at E8; ch_en[3] at E16; ON at E17.
- REQ-034: From ON, enable=0 at E0, delay_down=1 -> ch_en 0111 at E2, 0011 at E4, 0001 at E6, 0000 and OFF at E8.
- REQ-035: pgood[1] stuck 0, delay_up=3 -> ch_en[1] set at E8, FAULT at E27, ch_en=0000, fault_ch=1.
- REQ-036: In FAULT, fault_clr=1 with enable=1 -> stays FAULT; enable=0 with fault_clr=1 -> OFF next edge.
- REQ-037: RAMP_UP with ch_count=2, enable=0 -> RAMP_DOWN, ch_en[1] then ch_en[0] cleared; enable=1 again at ch_count=1 -> RAMP_UP resumes at ch_en[1].
